// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX round-robin arbiter.
// Defining UART_ARB_HDR_EN adds a per-grant header byte (HDR state).
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif

package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    UART_ARB_IDLE  = 2'd0,
    UART_ARB_GRANT = 2'd1
`ifdef UART_ARB_HDR_EN
    ,
    UART_ARB_HDR   = 2'd2
`endif
  } uart_arb_state_e;

`ifdef UART_ARB_HDR_EN
  // Header marker: MSB set, requester id is OR-ed into the low bits.
  localparam logic [`UART_DATA_WIDTH-1:0] UART_ARB_HDR_MARK =
    {1'b1, {(`UART_DATA_WIDTH-1){1'b0}}};
`endif

  function automatic int arb_wrap_inc(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request bit at or above the
// pointer, wrapping modulo P_REQ_NUM.
module uart_rr_picker #(
  parameter int P_REQ_NUM = 4,
  parameter int P_IDX_W   = $clog2(P_REQ_NUM)
) (
  input  logic [P_REQ_NUM-1:0] i_req,
  input  logic [P_IDX_W-1:0]   i_ptr,
  output logic [P_IDX_W-1:0]   o_idx,
  output logic                 o_any
);

  logic [P_IDX_W-1:0] cand;

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    cand  = '0;
    for (int i = 0; i < P_REQ_NUM; i++) begin
      cand = P_IDX_W'((int'(i_ptr) + i) % P_REQ_NUM);
      if (!o_any && i_req[cand]) begin
        o_idx = cand;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter between
// P_REQ_NUM byte producers. Optional header byte per grant: UART_ARB_HDR_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int P_REQ_NUM         = 4,
  parameter int P_UART_DATA_WIDTH = `UART_DATA_WIDTH,
  parameter int P_MAX_BURST       = 16
) (
  input  logic                                   i_u_clk,
  input  logic                                   i_u_rst,
  input  logic [P_REQ_NUM-1:0]                   i_req_valid,
  input  logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_REQ_NUM-1:0]                   i_req_last,
  output logic [P_REQ_NUM-1:0]                   o_req_ready,
  output logic [P_UART_DATA_WIDTH-1:0]           o_uart_tx_data,
  output logic                                   o_uart_tx_valid,
  input  logic                                   i_uart_tx_ready,
  output logic [$clog2(P_REQ_NUM)-1:0]           o_grant_id,
  output logic                                   o_busy
);

  localparam int IW = $clog2(P_REQ_NUM);
  localparam int CW = $clog2(P_MAX_BURST + 1);
  localparam int W  = P_UART_DATA_WIDTH;

  uart_arb_state_e state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [CW-1:0]   count_q, count_d;
  logic            busy_q, busy_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            accept;
  logic            release_now;
  logic [W-1:0]    lanes [P_REQ_NUM];

  uart_rr_picker #(
    .P_REQ_NUM (P_REQ_NUM),
    .P_IDX_W   (IW)
  ) u_picker (
    .i_req (i_req_valid),
    .i_ptr (rr_ptr_q),
    .o_idx (pick_idx),
    .o_any (pick_any)
  );

  always_comb begin
    for (int k = 0; k < P_REQ_NUM; k++) begin
      lanes[k] = i_req_data[k*W +: W];
    end
  end

`ifdef UART_ARB_HDR_EN
  logic [W-1:0] hdr_byte;

  always_comb begin
    hdr_byte         = W'(UART_ARB_HDR_MARK);
    hdr_byte[IW-1:0] = grant_id_q;
  end
`endif

  // Pass-through datapath: only the granted lane reaches the transmitter.
  always_comb begin
    o_uart_tx_valid = 1'b0;
    o_uart_tx_data  = '0;
    o_req_ready     = '0;
    case (state_q)
      UART_ARB_GRANT: begin
        o_uart_tx_valid         = i_req_valid[grant_id_q];
        o_uart_tx_data          = lanes[grant_id_q];
        o_req_ready[grant_id_q] = i_uart_tx_ready;
      end
`ifdef UART_ARB_HDR_EN
      UART_ARB_HDR: begin
        o_uart_tx_valid = 1'b1;
        o_uart_tx_data  = hdr_byte;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    accept      = (state_q == UART_ARB_GRANT) && i_req_valid[grant_id_q] && i_uart_tx_ready;
    release_now = accept && (i_req_last[grant_id_q] || (count_q == CW'(P_MAX_BURST - 1)));
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    count_d    = count_q;
    busy_d     = busy_q;
    case (state_q)
      UART_ARB_IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_idx;
          busy_d     = 1'b1;
          count_d    = '0;
`ifdef UART_ARB_HDR_EN
          state_d    = UART_ARB_HDR;
`else
          state_d    = UART_ARB_GRANT;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      UART_ARB_HDR: begin
        if (i_uart_tx_ready) begin
          state_d = UART_ARB_GRANT;
        end
      end
`endif
      UART_ARB_GRANT: begin
        // A stalled requester keeps the grant; there is deliberately no timeout.
        if (release_now) begin
          rr_ptr_d = IW'(arb_wrap_inc(int'(grant_id_q), P_REQ_NUM));
          count_d  = '0;
          busy_d   = 1'b0;
          state_d  = UART_ARB_IDLE;
        end else if (accept) begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = UART_ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_u_clk) begin
    if (i_u_rst) begin
      state_q    <= UART_ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
    end
  end

  assign o_grant_id = grant_id_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, burst cap 4).
// The header scenario is only built when UART_ARB_HDR_EN is defined.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b1;
  logic [1:0]     grant_id;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  int             tx_hold = 3;
  int             tx_cnt  = 0;
  logic [15:0]    tx_rec [$];

  logic [8:0]     rmem [N][64];
  int             rhead [N];
  int             rtail [N];
  logic [N-1:0]   nv;
  logic [N*W-1:0] nd;
  logic [N-1:0]   nl;

  uart_tx_arbiter #(
    .P_REQ_NUM         (N),
    .P_UART_DATA_WIDTH (W),
    .P_MAX_BURST       (MB)
  ) dut (
    .i_u_clk         (clk),
    .i_u_rst         (rst),
    .i_req_valid     (req_valid),
    .i_req_data      (req_data),
    .i_req_last      (req_last),
    .o_req_ready     (req_ready),
    .o_uart_tx_data  (tx_data),
    .o_uart_tx_valid (tx_valid),
    .i_uart_tx_ready (tx_ready),
    .o_grant_id      (grant_id),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  // Transmitter and producer models: ready drops for tx_hold cycles per byte,
  // producers present queued bytes and advance on their own handshake.
  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      tx_rec.push_back({6'd0, grant_id, tx_data});
      tx_ready <= 1'b0;
      tx_cnt   <= tx_hold;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_ready <= 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      if (req_valid[k] && req_ready[k]) rhead[k]++;
    end
    for (int k = 0; k < N; k++) begin
      nv[k]        = (rhead[k] != rtail[k]);
      nd[k*W +: W] = rmem[k][rhead[k]][7:0];
      nl[k]        = rmem[k][rhead[k]][8];
    end
    req_valid <= nv;
    req_data  <= nd;
    req_last  <= nl;
  end

  task automatic push(input int k, input logic [7:0] d, input logic l);
    rmem[k][rtail[k]] = {l, d};
    rtail[k]++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    bit pend;
    pend = 1'b1;
    while (pend && cyc < 600) begin
      @(negedge clk);
      cyc++;
      pend = busy || !tx_ready || (req_valid != '0);
      for (int k = 0; k < N; k++) if (rhead[k] != rtail[k]) pend = 1'b1;
    end
    n_cmp++;
    if (pend) begin
      n_bad++;
      $display("[TB] FAIL %s_timeout: still busy after %0d cycles, required idle", tag, cyc);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp += 6;
    if (tx_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_valid: got %b required 0", tx_valid); end
    if (req_ready !== 4'b0) begin n_bad++; $display("[TB] FAIL rst_ready: got %b required 0000", req_ready); end
    if (grant_id !== 2'd0) begin n_bad++; $display("[TB] FAIL rst_grant: got %0d required 0", grant_id); end
    if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
    if (dut.state_q !== UART_ARB_IDLE) begin n_bad++; $display("[TB] FAIL rst_state: got %0d required IDLE", dut.state_q); end
    if (dut.rr_ptr_q !== 2'd0) begin n_bad++; $display("[TB] FAIL rst_rr: got %0d required 0", dut.rr_ptr_q); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [15:0] exp_r [3] = '{16'h0111, 16'h0122, 16'h0133};
    logic [15:0] got;
    tx_hold = 10;
    tx_rec.delete();
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h33, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL single_pre_busy: got %b required 0", busy); end
    @(negedge clk);
    n_cmp += 2;
    if (grant_id !== 2'd1) begin n_bad++; $display("[TB] FAIL single_grant: got %0d required 1", grant_id); end
    if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL single_busy: got %b required 1", busy); end
    wait_idle("single");
    for (int i = 0; i < 3; i++) begin
      got = (i < tx_rec.size()) ? tx_rec[i] : 16'hxxxx;
      n_cmp++;
      if (got !== exp_r[i]) begin n_bad++; $display("[TB] FAIL single_rec%0d: got %h required %h", i, got, exp_r[i]); end
    end
    n_cmp += 3;
    if (tx_rec.size() != 3) begin n_bad++; $display("[TB] FAIL single_count: got %0d required 3", tx_rec.size()); end
    if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL single_busy_end: got %b required 0", busy); end
    if (dut.rr_ptr_q !== 2'd2) begin n_bad++; $display("[TB] FAIL single_rr: got %0d required 2", dut.rr_ptr_q); end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_r [8] = '{16'h0040, 16'h0141, 16'h0242, 16'h0343,
                               16'h0050, 16'h0151, 16'h0252, 16'h0353};
    logic [15:0] got;
    do_reset();
    tx_hold = 2;
    tx_rec.delete();
    for (int k = 0; k < N; k++) push(k, 8'h40 + 8'(k), 1'b1);
    for (int k = 0; k < N; k++) push(k, 8'h50 + 8'(k), 1'b1);
    wait_idle("rr");
    for (int i = 0; i < 8; i++) begin
      got = (i < tx_rec.size()) ? tx_rec[i] : 16'hxxxx;
      n_cmp++;
      if (got !== exp_r[i]) begin n_bad++; $display("[TB] FAIL rr_rec%0d: got %h required %h", i, got, exp_r[i]); end
    end
  endtask

  task automatic test_burst_cap();
    logic [15:0] exp_r [7] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                               16'h02A0, 16'h0005, 16'h0006};
    logic [15:0] got;
    do_reset();
    tx_hold = 2;
    tx_rec.delete();
    for (int i = 1; i <= 6; i++) push(0, 8'(i), (i == 6));
    push(2, 8'hA0, 1'b1);
    wait_idle("burst");
    for (int i = 0; i < 7; i++) begin
      got = (i < tx_rec.size()) ? tx_rec[i] : 16'hxxxx;
      n_cmp++;
      if (got !== exp_r[i]) begin n_bad++; $display("[TB] FAIL burst_rec%0d: got %h required %h", i, got, exp_r[i]); end
    end
  endtask

  task automatic test_valid_gap();
    logic [15:0] exp_r [3] = '{16'h0331, 16'h0332, 16'h0007};
    logic [15:0] got;
    bit bad_rdy;
    bit bad_gnt;
    int cyc;
    do_reset();
    tx_hold = 3;
    tx_rec.delete();
    push(3, 8'h31, 1'b0);
    cyc = 0;
    while (tx_rec.size() < 1 && cyc < 100) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (tx_rec.size() < 1) begin n_bad++; $display("[TB] FAIL gap_first_byte: got none after %0d cycles, required 1 byte", cyc); end
    push(0, 8'h07, 1'b1);
    bad_rdy = 1'b0;
    bad_gnt = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready[0] !== 1'b0) bad_rdy = 1'b1;
      if (grant_id !== 2'd3 || busy !== 1'b1) bad_gnt = 1'b1;
    end
    n_cmp += 2;
    if (bad_rdy !== 1'b0) begin n_bad++; $display("[TB] FAIL gap_req0_ready: got high during gap, required 0"); end
    if (bad_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL gap_grant_held: got grant moved, required grant 3 held"); end
    push(3, 8'h32, 1'b1);
    wait_idle("gap");
    for (int i = 0; i < 3; i++) begin
      got = (i < tx_rec.size()) ? tx_rec[i] : 16'hxxxx;
      n_cmp++;
      if (got !== exp_r[i]) begin n_bad++; $display("[TB] FAIL gap_rec%0d: got %h required %h", i, got, exp_r[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_r [6] = '{16'h0261, 16'h0171, 16'h0262, 16'h0263, 16'h0264, 16'h0265};
    logic [15:0] got;
    int cyc;
    do_reset();
    tx_hold = 3;
    tx_rec.delete();
    for (int i = 1; i <= 5; i++) push(2, 8'h60 + 8'(i), (i == 5));
    cyc = 0;
    while (tx_rec.size() < 1 && cyc < 100) begin @(negedge clk); cyc++; end
    push(1, 8'h71, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    n_cmp += 6;
    if (tx_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_valid: got %b required 0", tx_valid); end
    if (req_ready !== 4'b0) begin n_bad++; $display("[TB] FAIL mid_ready: got %b required 0000", req_ready); end
    if (grant_id !== 2'd0) begin n_bad++; $display("[TB] FAIL mid_grant: got %0d required 0", grant_id); end
    if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_busy: got %b required 0", busy); end
    if (dut.state_q !== UART_ARB_IDLE) begin n_bad++; $display("[TB] FAIL mid_state: got %0d required IDLE", dut.state_q); end
    if (dut.rr_ptr_q !== 2'd0) begin n_bad++; $display("[TB] FAIL mid_rr: got %0d required 0", dut.rr_ptr_q); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (grant_id !== 2'd1) begin n_bad++; $display("[TB] FAIL mid_regrant: got %0d required 1", grant_id); end
    if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_regrant_busy: got %b required 1", busy); end
    wait_idle("mid");
    for (int i = 0; i < 6; i++) begin
      got = (i < tx_rec.size()) ? tx_rec[i] : 16'hxxxx;
      n_cmp++;
      if (got !== exp_r[i]) begin n_bad++; $display("[TB] FAIL mid_rec%0d: got %h required %h", i, got, exp_r[i]); end
    end
  endtask

`ifdef UART_ARB_HDR_EN
  task automatic test_header();
    logic [15:0] exp_r [2] = '{16'h0282, 16'h025A};
    logic [15:0] got;
    do_reset();
    tx_hold = 3;
    tx_rec.delete();
    push(2, 8'h5A, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_cmp += 3;
    if (tx_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL hdr_valid: got %b required 1", tx_valid); end
    if (tx_data !== 8'h82) begin n_bad++; $display("[TB] FAIL hdr_data: got %h required 82", tx_data); end
    if (req_ready !== 4'b0) begin n_bad++; $display("[TB] FAIL hdr_ready: got %b required 0000", req_ready); end
    wait_idle("hdr");
    for (int i = 0; i < 2; i++) begin
      got = (i < tx_rec.size()) ? tx_rec[i] : 16'hxxxx;
      n_cmp++;
      if (got !== exp_r[i]) begin n_bad++; $display("[TB] FAIL hdr_rec%0d: got %h required %h", i, got, exp_r[i]); end
    end
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
`ifdef UART_ARB_HDR_EN
    test_header();
`else
    test_single();
    test_round_robin();
    test_burst_cap();
    test_valid_gap();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
